toy_arch_rename_table: RTL and testbench

- Committed (architectural) rename table for one register class; MODE selects int or fp behaviour, with a parametrised commit channel count and table depth.
- Updates the arch->phy map at commit, reports freed physical registers and the committed-live set to the freelist, and exposes the current map.
- Adds a recovery walker: on flush it streams the committed map to the speculative RAT, RECOVER_W entries per cycle.
- Sits beside the ROB commit stage; one instance per register class.

---
 rtl/toy_pack.sv | 20 ++
 rtl/toy_arch_rename_recover_walker.sv | 83 ++++++++
 rtl/toy_arch_rename_table_chk.sv | 24 ++
 rtl/toy_arch_rename_table.sv | 121 ++++++++++++
 tb/tb_toy_arch_rename_table.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/toy_pack.sv
// Shared constants and types for the committed rename table slice.
// Block parameters default to these values; the recovery struct describes one walker chunk.
package toy_pack;
   localparam int COMMIT_CH        = 32'd4;
   localparam int ARCH_NUM         = 32'd32;
   localparam int PHY_NUM          = 32'd128;
   localparam int RECOVER_W        = 32'd8;
   localparam int PHY_REG_ID_WIDTH = $clog2(PHY_NUM);
   localparam int ARCH_ID_WIDTH    = $clog2(ARCH_NUM);

   typedef enum logic [0:0] {
      REG_CLASS_INT = 1'b0,
      REG_CLASS_FP  = 1'b1
   } reg_class_e;

   typedef struct packed {
      logic [ARCH_ID_WIDTH-1:0]                         base;
      logic [RECOVER_W-1:0][PHY_REG_ID_WIDTH-1:0]       phy;
   } rename_recover_pkg;
endpackage

// File: rtl/toy_arch_rename_recover_walker.sv
// Flush recovery walker: streams the committed map RECOVER_W entries per cycle,
// then pulses recover_done for one cycle.
module toy_arch_rename_recover_walker
   import toy_pack::*;
#(
   parameter int ARCH_NUM  = 32'd32,
   parameter int PHY_W     = 32'd7,
   parameter int RECOVER_W = 32'd8,
   parameter int ARCH_W    = $clog2(ARCH_NUM)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [ARCH_NUM*PHY_W-1:0]         table_flat,
   input  logic                              recover_req,
   output logic                              recover_busy,
   output logic                              recover_vld,
   output logic [ARCH_W-1:0]                 recover_base,
   output logic [RECOVER_W-1:0][PHY_W-1:0]   recover_phy,
   output logic                              recover_done
);
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WALK = 2'd1,
      ST_DONE = 2'd2
   } walk_state_e;

   localparam logic [ARCH_W-1:0] LAST_IDX = ARCH_W'(ARCH_NUM - RECOVER_W);

   walk_state_e       state_r, state_nxt_s;
   logic [ARCH_W-1:0] idx_r, idx_nxt_s;

   // State and chunk index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         idx_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         idx_r   <= idx_nxt_s;
      end
   end

   // Next-state and index update; requests outside IDLE are dropped.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      case (state_r)
         ST_IDLE: begin
            idx_nxt_s = '0;
            if (recover_req) begin
               state_nxt_s = ST_WALK;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WALK: begin
            idx_nxt_s   = idx_r + ARCH_W'(RECOVER_W);
            state_nxt_s = (idx_r == LAST_IDX) ? ST_DONE : ST_WALK;
         end
         ST_DONE: begin
            idx_nxt_s   = '0;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            idx_nxt_s   = '0;
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Chunk mux reads the live table, so a walk always carries the newest committed values.
   always_comb begin
      recover_phy = '0;
      for (int w = 0; w < RECOVER_W; w++) begin
         recover_phy[w] = (state_r == ST_WALK) ? table_flat[(int'(idx_r) + w)*PHY_W +: PHY_W] : '0;
      end
   end

   assign recover_vld  = (state_r == ST_WALK);
   assign recover_busy = (state_r != ST_IDLE);
   assign recover_done = (state_r == ST_DONE);
   assign recover_base = (state_r == ST_WALK) ? idx_r : '0;
endmodule

// File: rtl/toy_arch_rename_table_chk.sv
// Protocol checks for the committed rename table: no commits during a walk,
// and every applied commit must actually change the mapping.
module toy_arch_rename_table_chk #(
   parameter int COMMIT_CH = 32'd4,
   parameter int PHY_W     = 32'd7
) (
   input logic                              clk,
   input logic                              rst_n,
   input logic [COMMIT_CH-1:0]              commit_en,
   input logic [COMMIT_CH-1:0]              commit_valid,
   input logic [COMMIT_CH-1:0][PHY_W-1:0]   old_phy,
   input logic [COMMIT_CH-1:0][PHY_W-1:0]   new_phy,
   input logic                              busy
);
   a_no_commit_busy: assert property (@(posedge clk) disable iff (!rst_n)
      !(busy && (|commit_en)));

   generate
      for (genvar c = 0; c < COMMIT_CH; c++) begin : g_ch
         a_phy_change: assert property (@(posedge clk) disable iff (!rst_n)
            commit_valid[c] |-> (old_phy[c] != new_phy[c]));
      end
   endgenerate
endmodule

// File: rtl/toy_arch_rename_table.sv
// Committed rename table: applies ordered multi-channel commits, reports freed and
// live physical registers, and hosts the flush recovery walker.
module toy_arch_rename_table #(
   parameter int COMMIT_CH = toy_pack::COMMIT_CH,
   parameter int ARCH_NUM  = toy_pack::ARCH_NUM,
   parameter int PHY_NUM   = toy_pack::PHY_NUM,
   parameter int RECOVER_W = toy_pack::RECOVER_W,
   parameter int MODE      = 32'd0,
   parameter int ARCH_W    = $clog2(ARCH_NUM),
   parameter int PHY_W     = $clog2(PHY_NUM)
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [COMMIT_CH-1:0]               v_commit_en,
   input  logic [COMMIT_CH-1:0][ARCH_W-1:0]   v_commit_arch,
   input  logic [COMMIT_CH-1:0][PHY_W-1:0]    v_commit_phy,
   output logic [PHY_NUM-1:0]                 v_phy_release_comb,
   output logic [PHY_NUM-1:0]                 v_phy_release,
   output logic [PHY_NUM-1:0]                 v_phy_back_ref,
   output logic [ARCH_NUM-1:0][PHY_W-1:0]     v_arch_phy_id,
   input  logic                               recover_req,
   output logic                               recover_busy,
   output logic                               recover_vld,
   output logic [ARCH_W-1:0]                  recover_base,
   output logic [RECOVER_W-1:0][PHY_W-1:0]    recover_phy,
   output logic                               recover_done
);
   import toy_pack::*;

   localparam bit HARD_ZERO = (MODE == int'(REG_CLASS_INT));

   logic [ARCH_NUM-1:0][PHY_W-1:0]   table_r, table_nxt_s;
   logic [PHY_NUM-1:0]               release_r, back_ref_r, back_ref_nxt_s;
   logic [COMMIT_CH-1:0]             valid_s;
   logic [COMMIT_CH-1:0][PHY_W-1:0]  old_phy_s;

   generate
      for (genvar c = 0; c < COMMIT_CH; c++) begin : g_ch
         logic [PHY_W-1:0] old_s;

         assign valid_s[c] = v_commit_en[c] && !(HARD_ZERO && (v_commit_arch[c] == '0));

         // Displaced value: the youngest earlier same-cycle write to this arch, else the table.
         always_comb begin
            old_s = table_r[v_commit_arch[c]];
            for (int j = 0; j < c; j++) begin
               old_s = (valid_s[j] && (v_commit_arch[j] == v_commit_arch[c])) ? v_commit_phy[j] : old_s;
            end
         end

         assign old_phy_s[c] = old_s;
      end
   endgenerate

   // Apply channels oldest-first; each applied write frees the value it displaces.
   always_comb begin
      table_nxt_s        = table_r;
      v_phy_release_comb = '0;
      for (int c = 0; c < COMMIT_CH; c++) begin
         v_phy_release_comb[old_phy_s[c]] = v_phy_release_comb[old_phy_s[c]] | valid_s[c];
         table_nxt_s[v_commit_arch[c]]    = valid_s[c] ? v_commit_phy[c] : table_nxt_s[v_commit_arch[c]];
      end
   end

   // Live set is taken from the next-state table so it stays coherent with the map outputs.
   always_comb begin
      back_ref_nxt_s = '0;
      for (int a = 0; a < ARCH_NUM; a++) begin
         back_ref_nxt_s[table_nxt_s[a]] = 1'b1;
      end
   end

   // Table, live set and release registers; reset is the identity map.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int a = 0; a < ARCH_NUM; a++) begin
            table_r[a] <= PHY_W'(a);
         end
         back_ref_r <= {{(PHY_NUM-ARCH_NUM){1'b0}}, {ARCH_NUM{1'b1}}};
         release_r  <= '0;
      end else begin
         table_r    <= table_nxt_s;
         back_ref_r <= back_ref_nxt_s;
         release_r  <= v_phy_release_comb;
      end
   end

   assign v_arch_phy_id  = table_r;
   assign v_phy_back_ref = back_ref_r;
   assign v_phy_release  = release_r;

   toy_arch_rename_recover_walker #(
      .ARCH_NUM  (ARCH_NUM),
      .PHY_W     (PHY_W),
      .RECOVER_W (RECOVER_W),
      .ARCH_W    (ARCH_W)
   ) u_walker (
      .clk          (clk),
      .rst_n        (rst_n),
      .table_flat   (table_r),
      .recover_req  (recover_req),
      .recover_busy (recover_busy),
      .recover_vld  (recover_vld),
      .recover_base (recover_base),
      .recover_phy  (recover_phy),
      .recover_done (recover_done)
   );

   toy_arch_rename_table_chk #(
      .COMMIT_CH (COMMIT_CH),
      .PHY_W     (PHY_W)
   ) u_chk (
      .clk          (clk),
      .rst_n        (rst_n),
      .commit_en    (v_commit_en),
      .commit_valid (valid_s),
      .old_phy      (old_phy_s),
      .new_phy      (v_commit_phy),
      .busy         (recover_busy)
   );
endmodule

// File: tb/tb_toy_arch_rename_table.sv
// Bench for the committed rename table: directed commit/recovery scenarios plus
// randomized commits, all checked against an array-based reference map.
module tb_toy_arch_rename_table;
   localparam int CH = 4;
   localparam int AN = 32;
   localparam int PN = 128;
   localparam int RW = 8;
   localparam int AW = 5;
   localparam int PW = 7;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic [CH-1:0]          en0, en1;
   logic [CH-1:0][AW-1:0]  arch0, arch1;
   logic [CH-1:0][PW-1:0]  phy0, phy1;
   logic [PN-1:0]          rel_c0, rel0, bref0, rel_c1, rel1, bref1;
   logic [AN-1:0][PW-1:0]  map0, map1;
   logic                   req0, busy0, vld0, done0, req1, busy1, vld1, done1;
   logic [AW-1:0]          base0, base1;
   logic [RW-1:0][PW-1:0]  rphy0, rphy1;

   int tests_run = 0;
   int tests_failed = 0;
   int model_map[AN];
   int free_q[$];

   toy_arch_rename_table #(.COMMIT_CH(CH), .ARCH_NUM(AN), .PHY_NUM(PN), .RECOVER_W(RW), .MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .v_commit_en(en0), .v_commit_arch(arch0), .v_commit_phy(phy0),
      .v_phy_release_comb(rel_c0), .v_phy_release(rel0), .v_phy_back_ref(bref0), .v_arch_phy_id(map0),
      .recover_req(req0), .recover_busy(busy0), .recover_vld(vld0), .recover_base(base0),
      .recover_phy(rphy0), .recover_done(done0));

   toy_arch_rename_table #(.COMMIT_CH(CH), .ARCH_NUM(AN), .PHY_NUM(PN), .RECOVER_W(RW), .MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .v_commit_en(en1), .v_commit_arch(arch1), .v_commit_phy(phy1),
      .v_phy_release_comb(rel_c1), .v_phy_release(rel1), .v_phy_back_ref(bref1), .v_arch_phy_id(map1),
      .recover_req(req1), .recover_busy(busy1), .recover_vld(vld1), .recover_base(base1),
      .recover_phy(rphy1), .recover_done(done1));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_reset();
      for (int a = 0; a < AN; a++) model_map[a] = a;
   endfunction

   // Int class: writes to arch 0 are dropped; otherwise each write frees whatever it replaces.
   function automatic logic [PN-1:0] model_commit(input logic [CH-1:0] en,
                                                  input logic [CH-1:0][AW-1:0] a,
                                                  input logic [CH-1:0][PW-1:0] p);
      logic [PN-1:0] r;
      r = '0;
      for (int c = 0; c < CH; c++) begin
         if (en[c] && (a[c] != 0)) begin
            r[model_map[a[c]]] = 1'b1;
            model_map[a[c]] = int'(p[c]);
         end
      end
      return r;
   endfunction

   function automatic logic [AN-1:0][PW-1:0] model_vec();
      logic [AN-1:0][PW-1:0] v;
      for (int a = 0; a < AN; a++) v[a] = PW'(model_map[a]);
      return v;
   endfunction

   function automatic logic [PN-1:0] model_bref();
      logic [PN-1:0] r;
      r = '0;
      for (int a = 0; a < AN; a++) r[model_map[a]] = 1'b1;
      return r;
   endfunction

   task automatic clear_inputs();
      en0 = '0; arch0 = '0; phy0 = '0; req0 = 1'b0;
      en1 = '0; arch1 = '0; phy1 = '0; req1 = 1'b0;
   endtask

   task automatic test_reset();
      logic [PN-1:0] exp_bref;
      exp_bref = {{(PN-AN){1'b0}}, {AN{1'b1}}};
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      tick();
      tests_run++;
      if (map0 !== model_vec()) begin
         $display("FAIL reset_map got %h exp %h", map0, model_vec()); tests_failed++;
      end
      tests_run++;
      if (bref0 !== exp_bref) begin
         $display("FAIL reset_back_ref got %h exp %h", bref0, exp_bref); tests_failed++;
      end
      tests_run++;
      if (rel0 !== '0) begin
         $display("FAIL reset_release got %h exp 0", rel0); tests_failed++;
      end
      tests_run++;
      if ({busy0, vld0, done0, base0, rphy0} !== '0) begin
         $display("FAIL reset_recover got busy=%b vld=%b done=%b base=%0d exp all 0", busy0, vld0, done0, base0);
         tests_failed++;
      end
   endtask

   task automatic test_single_commit();
      logic [PN-1:0] exp_rel;
      en0 = 4'b0010; arch0[1] = 5'd5; phy0[1] = 7'd40;
      exp_rel = model_commit(en0, arch0, phy0);
      #2;
      tests_run++;
      if (rel_c0 !== exp_rel || rel_c0[5] !== 1'b1) begin
         $display("FAIL single_release_comb got %h exp %h", rel_c0, exp_rel); tests_failed++;
      end
      tick();
      en0 = '0;
      tests_run++;
      if (rel0 !== exp_rel) begin
         $display("FAIL single_release_reg got %h exp %h", rel0, exp_rel); tests_failed++;
      end
      tests_run++;
      if (map0 !== model_vec() || map0[5] !== 7'd40) begin
         $display("FAIL single_map got %h exp %h", map0, model_vec()); tests_failed++;
      end
      tests_run++;
      if (bref0 !== model_bref() || bref0[40] !== 1'b1 || bref0[5] !== 1'b0) begin
         $display("FAIL single_back_ref got %h exp %h", bref0, model_bref()); tests_failed++;
      end
   endtask

   task automatic test_same_arch();
      logic [PN-1:0] exp_rel;
      en0 = 4'b0101; arch0[0] = 5'd7; phy0[0] = 7'd50; arch0[2] = 5'd7; phy0[2] = 7'd51;
      exp_rel = model_commit(en0, arch0, phy0);
      #2;
      tests_run++;
      if (rel_c0 !== exp_rel || rel_c0[7] !== 1'b1 || rel_c0[50] !== 1'b1) begin
         $display("FAIL same_arch_release_comb got %h exp %h", rel_c0, exp_rel); tests_failed++;
      end
      tick();
      en0 = '0;
      tests_run++;
      if (map0 !== model_vec() || map0[7] !== 7'd51) begin
         $display("FAIL same_arch_map got %h exp %h", map0, model_vec()); tests_failed++;
      end
      tests_run++;
      if (bref0 !== model_bref() || bref0[51] !== 1'b1 || bref0[50] !== 1'b0 || bref0[7] !== 1'b0) begin
         $display("FAIL same_arch_back_ref got %h exp %h", bref0, model_bref()); tests_failed++;
      end
   endtask

   task automatic test_arch0_mode();
      logic [PN-1:0] exp_rel1;
      exp_rel1 = '0;
      exp_rel1[0] = 1'b1;
      en0 = 4'b0001; arch0[0] = 5'd0; phy0[0] = 7'd60;
      en1 = 4'b0001; arch1[0] = 5'd0; phy1[0] = 7'd60;
      #2;
      tests_run++;
      if (rel_c0 !== '0) begin
         $display("FAIL arch0_int_release got %h exp 0", rel_c0); tests_failed++;
      end
      tests_run++;
      if (rel_c1 !== exp_rel1) begin
         $display("FAIL arch0_fp_release got %h exp %h", rel_c1, exp_rel1); tests_failed++;
      end
      tick();
      en0 = '0; en1 = '0;
      tests_run++;
      if (map0[0] !== 7'd0 || map0 !== model_vec()) begin
         $display("FAIL arch0_int_map got %h exp %h", map0, model_vec()); tests_failed++;
      end
      tests_run++;
      if (map1[0] !== 7'd60 || bref1[60] !== 1'b1 || bref1[0] !== 1'b0 || rel1 !== exp_rel1) begin
         $display("FAIL arch0_fp_state got entry0=%0d bref60=%b bref0=%b rel=%h exp 60 1 0 %h",
                  map1[0], bref1[60], bref1[0], rel1, exp_rel1);
         tests_failed++;
      end
   endtask

   task automatic test_random_commits();
      logic [PN-1:0] exp_rel;
      logic held [PN];
      int idx;
      for (int p = 0; p < PN; p++) held[p] = 1'b0;
      for (int a = 0; a < AN; a++) held[model_map[a]] = 1'b1;
      free_q.delete();
      for (int p = 0; p < PN; p++) if (!held[p]) free_q.push_back(p);
      for (int cyc = 0; cyc < 300; cyc++) begin
         for (int c = 0; c < CH; c++) begin
            en0[c] = 1'($urandom_range(0, 1));
            arch0[c] = ($urandom_range(0, 2) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, AN-1));
            idx = $urandom_range(0, free_q.size()-1);
            phy0[c] = PW'(free_q[idx]);
            free_q.delete(idx);
         end
         exp_rel = model_commit(en0, arch0, phy0);
         for (int c = 0; c < CH; c++) if (!en0[c] || arch0[c] == 0) free_q.push_back(int'(phy0[c]));
         for (int p = 0; p < PN; p++) if (exp_rel[p]) free_q.push_back(p);
         #2;
         tests_run++;
         if (rel_c0 !== exp_rel) begin
            $display("FAIL rand_release_comb cyc %0d got %h exp %h", cyc, rel_c0, exp_rel); tests_failed++;
         end
         tick();
         tests_run++;
         if (rel0 !== exp_rel) begin
            $display("FAIL rand_release_reg cyc %0d got %h exp %h", cyc, rel0, exp_rel); tests_failed++;
         end
         tests_run++;
         if (map0 !== model_vec()) begin
            $display("FAIL rand_map cyc %0d got %h exp %h", cyc, map0, model_vec()); tests_failed++;
         end
         tests_run++;
         if (bref0 !== model_bref()) begin
            $display("FAIL rand_back_ref cyc %0d got %h exp %h", cyc, bref0, model_bref()); tests_failed++;
         end
      end
      en0 = '0;
      tick();
   endtask

   task automatic test_recover();
      logic [RW-1:0][PW-1:0] exp_chunk;
      req0 = 1'b1;
      tick();
      req0 = 1'b0;
      for (int k = 0; k < AN/RW; k++) begin
         for (int w = 0; w < RW; w++) exp_chunk[w] = PW'(model_map[k*RW + w]);
         tests_run++;
         if (vld0 !== 1'b1 || busy0 !== 1'b1 || done0 !== 1'b0 || base0 !== AW'(k*RW) || rphy0 !== exp_chunk) begin
            $display("FAIL recover_chunk %0d got vld=%b busy=%b done=%b base=%0d phy=%h exp 1 1 0 %0d %h",
                     k, vld0, busy0, done0, base0, rphy0, k*RW, exp_chunk);
            tests_failed++;
         end
         req0 = (k == 1);
         tick();
      end
      req0 = 1'b0;
      tests_run++;
      if (done0 !== 1'b1 || busy0 !== 1'b1 || vld0 !== 1'b0) begin
         $display("FAIL recover_done got done=%b busy=%b vld=%b exp 1 1 0", done0, busy0, vld0); tests_failed++;
      end
      tick();
      tests_run++;
      if (done0 !== 1'b0 || busy0 !== 1'b0 || vld0 !== 1'b0) begin
         $display("FAIL recover_idle got done=%b busy=%b vld=%b exp 0 0 0", done0, busy0, vld0); tests_failed++;
      end
      repeat (3) tick();
      tests_run++;
      if (busy0 !== 1'b0) begin
         $display("FAIL recover_req_while_busy got busy=%b exp 0", busy0); tests_failed++;
      end
   endtask

   task automatic test_reset_mid_walk();
      logic saw_done;
      saw_done = 1'b0;
      req0 = 1'b1;
      tick();
      req0 = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      model_reset();
      tests_run++;
      if (busy0 !== 1'b0 || vld0 !== 1'b0 || done0 !== 1'b0) begin
         $display("FAIL midwalk_async got busy=%b vld=%b done=%b exp 0 0 0", busy0, vld0, done0); tests_failed++;
      end
      tests_run++;
      if (map0 !== model_vec() || bref0 !== model_bref()) begin
         $display("FAIL midwalk_table got %h exp %h", map0, model_vec()); tests_failed++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (done0 !== 1'b0 || busy0 !== 1'b0) saw_done = 1'b1;
      end
      tests_run++;
      if (saw_done !== 1'b0) begin
         $display("FAIL midwalk_no_done got activity=%b exp 0", saw_done); tests_failed++;
      end
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      test_reset();
      test_single_commit();
      test_same_arch();
      test_arch0_mode();
      test_random_commits();
      test_recover();
      test_reset_mid_walk();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
